// File: rtl/adc_ro_buf_fifo_pkg.sv
// Shared constants for the ADC readout sample buffer.
// Sample width and buffer depth used by the FIFO and its RAM.
package adc_ro_pkg;

   localparam int ADC_SAMPLE_WIDTH   = 16;
   localparam int ADC_BUF_ADDR_WIDTH = 4;

   typedef struct packed {
      logic wr;
      logic rd;
   } adc_ro_acc_t;

   // Occupancy after one edge given which requests were accepted.
   function automatic logic [ADC_BUF_ADDR_WIDTH:0] adc_ro_next_count(
      input logic [ADC_BUF_ADDR_WIDTH:0] cnt,
      input adc_ro_acc_t                 acc
   );
      logic [ADC_BUF_ADDR_WIDTH:0] res;
      res = cnt;
      if (acc.wr && !acc.rd) res = cnt + 1'b1;
      else if (acc.rd && !acc.wr) res = cnt - 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/adc_ro_buf_fifo_if.sv
// Write/read bus of the ADC readout sample buffer.
// master drives requests and write data; slave is the FIFO.
interface adc_ro_buf_fifo_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] din;
   logic                  wr_en;
   logic                  full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  valid;
   logic                  empty;
   logic [ADDR_WIDTH:0]   data_count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output din, wr_en, rd_en,
      input  full, dout, valid, empty, data_count, overflow, underflow
   );

   modport slave (
      input  din, wr_en, rd_en,
      output full, dout, valid, empty, data_count, overflow, underflow
   );
endinterface

// File: rtl/adc_ro_buf_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read.
// The array itself is not reset; only the read register is.
module adc_ro_buf_ram
   import adc_ro_pkg::*;
#(
   parameter int DATA_WIDTH = ADC_SAMPLE_WIDTH,
   parameter int ADDR_WIDTH = ADC_BUF_ADDR_WIDTH
) (
   input  logic                  clk_100,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_100) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register holds its value when no read is enabled.
   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_ro_buf_fifo.sv
// First-word-not-fall-through buffer FIFO for ADC samples.
// Pointers, occupancy, flags and strobes live here; storage in adc_ro_buf_ram.
module adc_ro_buf_fifo
   import adc_ro_pkg::*;
#(
   parameter int DATA_WIDTH = ADC_SAMPLE_WIDTH,
   parameter int ADDR_WIDTH = ADC_BUF_ADDR_WIDTH
) (
   input  logic               clk_100,
   input  logic               rst,
   adc_ro_buf_fifo_if.slave   bus
);

   localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   adc_ro_acc_t           acc;
   logic [DATA_WIDTH-1:0] dout_w;

   // Flags gate both sides even when the other side frees/fills a slot.
   always_comb begin
      acc.wr   = bus.wr_en & ~full_q;
      acc.rd   = bus.rd_en & ~empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (acc.wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (acc.rd) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = adc_ro_next_count(count_q, acc);
      full_d   = (count_d == FULL_CNT);
      empty_d  = (count_d == '0);
      valid_d  = acc.rd;
      ovf_d    = bus.wr_en & full_q;
      unf_d    = bus.rd_en & empty_q;
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   adc_ro_buf_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk_100 (clk_100),
      .rst     (rst),
      .we_i    (acc.wr),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.din),
      .re_i    (acc.rd),
      .raddr_i (rd_ptr_q),
      .rdata_o (dout_w)
   );

   assign bus.dout       = dout_w;
   assign bus.valid      = valid_q;
   assign bus.full       = full_q;
   assign bus.empty      = empty_q;
   assign bus.data_count = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.underflow  = unf_q;

endmodule

// File: tb/tb_adc_ro_buf_fifo.sv
// Bench for adc_ro_buf_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO.
module tb_adc_ro_buf_fifo;
   import adc_ro_pkg::*;

   logic clk_100 = 1'b0;
   logic rst     = 1'b1;

   adc_ro_buf_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

   adc_ro_buf_fifo dut (
      .clk_100 (clk_100),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk_100 = ~clk_100;

   int total = 0;
   int bad   = 0;

   logic [15:0] mq [$];
   int e_dout  = 0;
   int e_valid = 0;
   int e_ovf   = 0;
   int e_unf   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".dout"},  int'(bus.dout), e_dout);
      chk({ph, ".valid"}, int'(bus.valid), e_valid);
      chk({ph, ".count"}, int'(bus.data_count), mq.size());
      chk({ph, ".full"},  int'(bus.full), int'(mq.size() == 16));
      chk({ph, ".empty"}, int'(bus.empty), int'(mq.size() == 0));
      chk({ph, ".ovf"},   int'(bus.overflow), e_ovf);
      chk({ph, ".unf"},   int'(bus.underflow), e_unf);
   endtask

   // Called at posedge+1; drives requests, advances model, checks after edge.
   task automatic cycle(input string ph, input bit w,
                        input logic [15:0] d, input bit r);
      bit was_full;
      bit was_empty;
      was_full   = (mq.size() == 16);
      was_empty  = (mq.size() == 0);
      bus.wr_en  = w;
      bus.din    = d;
      bus.rd_en  = r;
      e_valid    = 0;
      e_ovf      = int'(w && was_full);
      e_unf      = int'(r && was_empty);
      if (r && !was_empty) begin
         e_dout  = int'(mq.pop_front());
         e_valid = 1;
      end
      if (w && !was_full) mq.push_back(d);
      @(posedge clk_100);
      #1;
      check_all(ph);
   endtask

   task automatic do_reset(input string ph);
      #3 rst = 1'b1;
      #1;
      mq.delete();
      e_dout  = 0;
      e_valid = 0;
      e_ovf   = 0;
      e_unf   = 0;
      check_all({ph, ".async"});
      @(posedge clk_100);
      #1;
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      check_all({ph, ".held"});
   endtask

   initial begin
      logic [15:0] k;
      int pw;
      bus.din   = '0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      repeat (2) @(posedge clk_100);
      #1;
      rst = 1'b0;
      check_all("rst");
      cycle("idle", 0, 16'h0, 0);

      for (int i = 1; i <= 16; i++) cycle("fill", 1, 16'(i), 0);
      cycle("ovf", 1, 16'hBEEF, 0);
      cycle("ovf2", 0, 16'h0, 0);
      cycle("ovf_rw", 1, 16'hBEEF, 1);
      cycle("refill", 1, 16'h0011, 0);
      for (int i = 0; i < 16; i++) cycle("drain", 0, 16'h0, 1);
      cycle("tail", 0, 16'h0, 0);

      cycle("unf", 0, 16'h0, 1);
      cycle("unf_rw", 1, 16'h1234, 1);
      cycle("rd1234", 0, 16'h0, 1);
      cycle("idle2", 0, 16'h0, 0);

      k = 16'h0100;
      for (int i = 0; i < 8; i++) begin
         cycle("pre8", 1, k, 0);
         k++;
      end
      for (int i = 0; i < 40; i++) begin
         cycle("rw8", 1, k, 1);
         k++;
      end

      do_reset("rst_a");
      cycle("post_rst", 0, 16'h0, 0);
      for (int i = 0; i < 5; i++) cycle("five", 1, 16'(16'h0A00 + i), 0);
      cycle("rd_one", 0, 16'h0, 1);
      bus.rd_en = 1'b1;
      do_reset("rst_mid");
      cycle("a5w", 1, 16'hA5A5, 0);
      cycle("a5r", 0, 16'h0, 1);
      cycle("a5i", 0, 16'h0, 0);

      pw = 50;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) pw = int'($urandom_range(10, 90));
         if (i == 300) do_reset("rst_rand");
         cycle("rand",
               $urandom_range(0, 99) < pw,
               16'($urandom),
               $urandom_range(0, 99) < (100 - pw));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
